// File: rtl/sdram_cache_ctrl_pkg.sv
// Shared definitions for the SDRAM cache controller: FSM encoding, data/mask
// widths and the address-slicing helpers used by the controller.
// No logic, no latency, no backpressure: types and pure functions only.
package sdram_cache_ctrl_pkg;

    localparam int DATA_W = 32;
    localparam int MASK_W = 4;

    localparam logic [6:0] ST_INIT    = 7'd0;
    localparam logic [6:0] ST_IDLE    = 7'd1;
    localparam logic [6:0] ST_LOOKUP  = 7'd2;
    localparam logic [6:0] ST_RD_MISS = 7'd3;
    localparam logic [6:0] ST_WR_MEM  = 7'd4;

    typedef enum logic [6:0] {
        S_INIT    = ST_INIT,
        S_IDLE    = ST_IDLE,
        S_LOOKUP  = ST_LOOKUP,
        S_RD_MISS = ST_RD_MISS,
        S_WR_MEM  = ST_WR_MEM
    } state_e;

    // Line index: word address bits [index_bits+1:2]. Caller narrows the result.
    function automatic logic [63:0] addr_index(input logic [63:0] addr, input int index_bits);
        return (addr >> 2) & ((64'd1 << index_bits) - 64'd1);
    endfunction

    // Tag: everything above the index. Caller narrows the result.
    function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int index_bits);
        return addr >> (index_bits + 2);
    endfunction

endpackage

// File: rtl/sdram_cache_ctrl_line_ram.sv
// Line store of {valid, tag, data} with byte-write on data and a valid-clear port.
// Latency: read data registered, available the cycle after rd_en. Writes take effect next cycle.
// Backpressure: none; the controller never reads and writes the same line in one cycle.
// Ports: rd_en/rd_idx -> rd_valid/rd_tag/rd_data; wr_en/wr_idx/wr_meta/wr_tag/wr_data/wr_be;
//        clr_en/clr_idx clears a valid bit (takes priority over a meta write).
module cache_line_ram
    import sdram_cache_ctrl_pkg::*;
#(
    parameter int INDEX_BITS = 10,
    parameter int TAG_W      = 20
) (
    input  logic                  clk,
    input  logic                  rd_en,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output logic                  rd_valid,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [DATA_W-1:0]     rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic                  wr_meta,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [MASK_W-1:0]     wr_be,
    input  logic                  clr_en,
    input  logic [INDEX_BITS-1:0] clr_idx
);

    localparam int DEPTH = 1 << INDEX_BITS;

    logic                valid_mem [DEPTH];
    logic [TAG_W-1:0]    tag_mem   [DEPTH];
    logic [DATA_W-1:0]   data_mem  [DEPTH];

    logic                rd_valid_q;
    logic [TAG_W-1:0]    rd_tag_q;
    logic [DATA_W-1:0]   rd_data_q;

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_valid_q <= valid_mem[rd_idx];
            rd_tag_q   <= tag_mem[rd_idx];
            rd_data_q  <= data_mem[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (clr_en) begin
            valid_mem[clr_idx] <= 1'b0;
        end else if (wr_en && wr_meta) begin
            valid_mem[wr_idx] <= 1'b1;
            tag_mem[wr_idx]   <= wr_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < MASK_W; b++) begin
                if (wr_be[b]) begin
                    data_mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_tag   = rd_tag_q;
    assign rd_data  = rd_data_q;

endmodule

// File: rtl/sdram_cache_ctrl.sv
// Direct-mapped write-through one-word-line cache between the SRAM wrapper and an SDRAM req/ack port.
// Latency: read hit data in the cycle after i_rd_en; misses/writes wait for mem_ack (+1 cycle for fill data).
// Backpressure: o_busy high in INIT/RD_MISS/WR_MEM and on a lookup miss; mem_req held until mem_ack.
// Ports: clk/rst_x; user side i_rd_en/i_wr_en/i_addr/i_data/i_mask -> o_data/o_busy/c_oe/w_init_done/state;
//        backend side mem_req/mem_we/mem_addr/mem_wdata/mem_wmask <- mem_ack/mem_rdata.
module sdram_cache_ctrl
    import sdram_cache_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int INDEX_BITS = 10
) (
    input  logic                  clk,
    input  logic                  rst_x,
    output logic                  w_init_done,
    input  logic                  i_rd_en,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]           i_data,
    input  logic [3:0]            i_mask,
    output logic [31:0]           o_data,
    output logic                  o_busy,
    output logic [6:0]            state,
    output logic                  c_oe,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_wmask,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata
);

    localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - 2;
    localparam logic [INDEX_BITS-1:0] IDX_LAST = '1;

    state_e                  state_q, state_d;
    logic [INDEX_BITS-1:0]   init_idx_q, init_idx_d;
    logic                    init_done_q, init_done_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic [MASK_W-1:0]       mask_q, mask_d;
    logic [DATA_W-1:0]       odata_q, odata_d;
    logic                    fill_oe_q, fill_oe_d;

    logic [INDEX_BITS-1:0]   req_idx, cur_idx;
    logic [TAG_W-1:0]        cur_tag;
    logic                    hit;

    logic                    ram_rd_en;
    logic                    ram_rd_valid;
    logic [TAG_W-1:0]        ram_rd_tag;
    logic [DATA_W-1:0]       ram_rd_data;
    logic                    ram_wr_en;
    logic                    ram_wr_meta;
    logic [DATA_W-1:0]       ram_wr_data;
    logic [MASK_W-1:0]       ram_wr_be;
    logic                    ram_clr_en;

    assign req_idx = INDEX_BITS'(addr_index(64'(i_addr), INDEX_BITS));
    assign cur_idx = INDEX_BITS'(addr_index(64'(addr_q), INDEX_BITS));
    assign cur_tag = TAG_W'(addr_tag(64'(addr_q), INDEX_BITS));

    // Line RAM output always belongs to addr_q: it is only re-read when addr_q is reloaded.
    assign hit = ram_rd_valid && (ram_rd_tag == cur_tag);

    cache_line_ram #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_W      (TAG_W)
    ) u_line_ram (
        .clk      (clk),
        .rd_en    (ram_rd_en),
        .rd_idx   (req_idx),
        .rd_valid (ram_rd_valid),
        .rd_tag   (ram_rd_tag),
        .rd_data  (ram_rd_data),
        .wr_en    (ram_wr_en),
        .wr_idx   (cur_idx),
        .wr_meta  (ram_wr_meta),
        .wr_tag   (cur_tag),
        .wr_data  (ram_wr_data),
        .wr_be    (ram_wr_be),
        .clr_en   (ram_clr_en),
        .clr_idx  (init_idx_q)
    );

    always_ff @(posedge clk or posedge rst_x) begin
        if (rst_x) begin
            state_q     <= S_INIT;
            init_idx_q  <= '0;
            init_done_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mask_q      <= '0;
            odata_q     <= '0;
            fill_oe_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_idx_q  <= init_idx_d;
            init_done_q <= init_done_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mask_q      <= mask_d;
            odata_q     <= odata_d;
            fill_oe_q   <= fill_oe_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        init_idx_d  = init_idx_q;
        init_done_d = init_done_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mask_d      = mask_q;
        odata_d     = odata_q;
        fill_oe_d   = 1'b0;
        ram_rd_en   = 1'b0;
        ram_wr_en   = 1'b0;
        ram_wr_meta = 1'b0;
        ram_wr_data = wdata_q;
        ram_wr_be   = mask_q;
        ram_clr_en  = 1'b0;
        o_busy      = 1'b1;
        o_data      = odata_q;
        c_oe        = fill_oe_q;
        mem_req     = 1'b0;
        mem_we      = 1'b0;

        case (state_q)
            S_INIT: begin
                ram_clr_en = 1'b1;
                init_idx_d = init_idx_q + INDEX_BITS'(1);
                if (init_idx_q == IDX_LAST) begin
                    init_done_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_rd_en) begin
                    addr_d    = i_addr;
                    ram_rd_en = 1'b1;
                    state_d   = S_LOOKUP;
                end else if (i_wr_en) begin
                    // Line is read too, so WR_MEM can tell whether to merge.
                    addr_d    = i_addr;
                    wdata_d   = i_data;
                    mask_d    = i_mask;
                    ram_rd_en = 1'b1;
                    state_d   = S_WR_MEM;
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    o_busy  = 1'b0;
                    o_data  = ram_rd_data;
                    odata_d = ram_rd_data;
                    c_oe    = 1'b1;
                    if (i_rd_en) begin
                        addr_d    = i_addr;
                        ram_rd_en = 1'b1;
                        state_d   = S_LOOKUP;
                    end else begin
                        state_d   = S_IDLE;
                    end
                end else begin
                    state_d = S_RD_MISS;
                end
            end
            S_RD_MISS: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ram_wr_en   = 1'b1;
                    ram_wr_meta = 1'b1;
                    ram_wr_data = mem_rdata;
                    ram_wr_be   = '1;
                    odata_d     = mem_rdata;
                    fill_oe_d   = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_WR_MEM: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                // Merge repeats every cycle while waiting; it rewrites the same
                // bytes with the same value, so only the first one matters.
                if (hit) begin
                    ram_wr_en = 1'b1;
                end
                if (mem_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    assign w_init_done = init_done_q;
    assign state       = state_q;
    assign mem_addr    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign mem_wdata   = wdata_q;
    assign mem_wmask   = mask_q;

endmodule

// File: tb/tb_sdram_cache_ctrl.sv
module tb_sdram_cache_ctrl;

    logic        clk;
    logic        rst_x;
    logic        w_init_done;
    logic        i_rd_en;
    logic        i_wr_en;
    logic [31:0] i_addr;
    logic [31:0] i_data;
    logic [3:0]  i_mask;
    logic [31:0] o_data;
    logic        o_busy;
    logic [6:0]  state;
    logic        c_oe;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    // Scoreboard of expected read data, popped on every c_oe pulse.
    logic [31:0] exp_q [$];
    int          coe_cnt = 0;
    int          req_cyc = 0;

    // Backend model state.
    logic [31:0] mem_model [logic [31:0]];
    int          be_lat   = 5;
    int          be_cnt   = 0;
    int          ack_cnt  = 0;
    logic        last_we;
    logic [31:0] last_addr;
    logic [3:0]  last_mask;
    logic [31:0] last_wdata;

    sdram_cache_ctrl #(
        .ADDR_WIDTH (32),
        .INDEX_BITS (10)
    ) dut (
        .clk         (clk),
        .rst_x       (rst_x),
        .w_init_done (w_init_done),
        .i_rd_en     (i_rd_en),
        .i_wr_en     (i_wr_en),
        .i_addr      (i_addr),
        .i_data      (i_data),
        .i_mask      (i_mask),
        .o_data      (o_data),
        .o_busy      (o_busy),
        .state       (state),
        .c_oe        (c_oe),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wmask   (mem_wmask),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Backend: acknowledges after be_lat cycles of mem_req, one-cycle ack.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_ack) begin
                mem_ack = 1'b0;
                be_cnt  = 0;
            end else if (mem_req && !rst_x) begin
                if (be_cnt == be_lat - 1) begin
                    mem_ack    = 1'b1;
                    ack_cnt++;
                    last_we    = mem_we;
                    last_addr  = mem_addr;
                    last_mask  = mem_wmask;
                    last_wdata = mem_wdata;
                    if (!mem_model.exists(mem_addr)) mem_model[mem_addr] = 32'h0BAD0000 | mem_addr;
                    if (mem_we) begin
                        for (int b = 0; b < 4; b++)
                            if (mem_wmask[b]) mem_model[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
                    end else begin
                        mem_rdata = mem_model[mem_addr];
                    end
                end else begin
                    be_cnt++;
                end
            end else begin
                be_cnt = 0;
            end
        end
    end

    // Read-data monitor.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (mem_req) req_cyc++;
            if (c_oe) begin
                coe_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_c_oe", 32'(c_oe), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_data", o_data, e);
                end
            end
        end
    end

    task automatic wait_init();
        int cyc;
        cyc = 0;
        for (int k = 0; k < 2000; k++) begin
            tick();
            cyc++;
            smp();
            if (w_init_done) break;
            if (o_busy !== 1'b1) chk("init_busy", 32'(o_busy), 32'h1);
        end
        chk("init_cycles", 32'(cyc), 32'd1024);
        chk("init_done_busy", 32'(o_busy), 32'h0);
        chk("init_done_state", 32'(state), 32'd1);
    endtask

    task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] exp, input bit expect_hit);
        int coe0, ack0, req0, busy_cyc;
        coe0 = coe_cnt; ack0 = ack_cnt; req0 = req_cyc;
        tick();
        i_rd_en = 1'b1;
        i_addr  = a;
        exp_q.push_back(exp);
        tick();
        i_rd_en = 1'b0;
        smp();
        if (expect_hit) begin
            chk({tag, "_hit_busy"}, 32'(o_busy), 32'h0);
            chk({tag, "_hit_coe"}, 32'(c_oe), 32'h1);
        end else begin
            busy_cyc = 0;
            for (int k = 0; k < 100; k++) begin
                if (!o_busy) break;
                busy_cyc++;
                tick();
                smp();
            end
            chk({tag, "_miss_busy_cycles"}, 32'(busy_cyc), 32'(be_lat + 1));
            chk({tag, "_miss_last_we"}, 32'(last_we), 32'h0);
            chk({tag, "_miss_addr"}, last_addr, {a[31:2], 2'b00});
        end
        tick();
        smp();
        chk({tag, "_coe_count"}, 32'(coe_cnt - coe0), 32'd1);
        chk({tag, "_acks"}, 32'(ack_cnt - ack0), expect_hit ? 32'd0 : 32'd1);
        if (expect_hit) chk({tag, "_req_cycles"}, 32'(req_cyc - req0), 32'd0);
    endtask

    task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] m, input logic [31:0] held_odata);
        int ack0;
        ack0 = ack_cnt;
        tick();
        i_wr_en = 1'b1;
        i_addr  = a;
        i_data  = d;
        i_mask  = m;
        smp();
        tick();
        smp();
        chk({tag, "_busy"}, 32'(o_busy), 32'h1);
        chk({tag, "_req"}, 32'(mem_req), 32'h1);
        chk({tag, "_we"}, 32'(mem_we), 32'h1);
        chk({tag, "_wmask"}, 32'(mem_wmask), 32'(m));
        chk({tag, "_wdata"}, mem_wdata, d);
        tick();
        i_wr_en = 1'b0;
        for (int k = 0; k < 100; k++) begin
            smp();
            if (!o_busy) break;
            tick();
        end
        chk({tag, "_done_busy"}, 32'(o_busy), 32'h0);
        chk({tag, "_acks"}, 32'(ack_cnt - ack0), 32'd1);
        chk({tag, "_ack_addr"}, last_addr, {a[31:2], 2'b00});
        chk({tag, "_odata_held"}, o_data, held_odata);
    endtask

    initial begin
        int coe0, req0;
        rst_x   = 1'b1;
        i_rd_en = 1'b0;
        i_wr_en = 1'b0;
        i_addr  = 32'h0;
        i_data  = 32'h0;
        i_mask  = 4'h0;
        mem_model[32'h100] = 32'hDEADBEEF;
        mem_model[32'h104] = 32'hCAFE0104;
        mem_model[32'h1100] = 32'h11001100;

        // Reset state.
        tick();
        tick();
        smp();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_init_done", 32'(w_init_done), 32'h0);
        chk("rst_busy", 32'(o_busy), 32'h1);
        chk("rst_odata", o_data, 32'h0);
        chk("rst_coe", 32'(c_oe), 32'h0);
        chk("rst_req", 32'(mem_req), 32'h0);
        chk("rst_we", 32'(mem_we), 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wmask", 32'(mem_wmask), 32'h0);

        tick();
        rst_x = 1'b0;
        wait_init();

        // Cold miss, then hit on the same line.
        be_lat = 5;
        do_read("cold", 32'h100, 32'hDEADBEEF, 1'b0);
        do_read("rehit", 32'h100, 32'hDEADBEEF, 1'b1);

        // Write hit merges byte 0; backend sees the write.
        do_write("wr100", 32'h100, 32'h000000AA, 4'b0001, 32'hDEADBEEF);
        chk("wr100_ack_mask", 32'(last_mask), 32'h1);
        do_read("after_wr", 32'h100, 32'hDEADBEAA, 1'b1);

        // Alias evicts the line.
        do_read("alias", 32'h1100, 32'h11001100, 1'b0);
        do_read("evicted", 32'h100, 32'hDEADBEAA, 1'b0);

        // Write miss does not allocate.
        do_write("wrmiss", 32'h208, 32'h55667788, 4'b1111, 32'hDEADBEAA);
        do_read("wrmiss_rd", 32'h208, 32'h55667788, 1'b0);

        // Back-to-back hits.
        do_read("fill104", 32'h104, 32'hCAFE0104, 1'b0);
        coe0 = coe_cnt;
        req0 = req_cyc;
        tick();
        i_rd_en = 1'b1;
        i_addr  = 32'h100;
        exp_q.push_back(32'hDEADBEAA);
        tick();
        i_addr  = 32'h104;
        exp_q.push_back(32'hCAFE0104);
        smp();
        chk("b2b_1_busy", 32'(o_busy), 32'h0);
        chk("b2b_1_coe", 32'(c_oe), 32'h1);
        tick();
        i_rd_en = 1'b0;
        smp();
        chk("b2b_2_state", 32'(state), 32'd2);
        chk("b2b_2_coe", 32'(c_oe), 32'h1);
        tick();
        smp();
        chk("b2b_idle", 32'(state), 32'd1);
        chk("b2b_coe_count", 32'(coe_cnt - coe0), 32'd2);
        chk("b2b_req_cycles", 32'(req_cyc - req0), 32'd0);

        // Reset while waiting in RD_MISS.
        be_lat = 30;
        tick();
        i_rd_en = 1'b1;
        i_addr  = 32'h400;
        tick();
        i_rd_en = 1'b0;
        smp();
        tick();
        smp();
        chk("miss_state", 32'(state), 32'd3);
        chk("miss_req", 32'(mem_req), 32'h1);
        #2;
        rst_x = 1'b1;
        #1;
        chk("midrst_req", 32'(mem_req), 32'h0);
        chk("midrst_state", 32'(state), 32'd0);
        chk("midrst_init_done", 32'(w_init_done), 32'h0);
        chk("midrst_busy", 32'(o_busy), 32'h1);
        tick();
        tick();
        rst_x = 1'b0;
        wait_init();

        // Sweep cleared every line: previously cached 0x100 misses again.
        be_lat = 3;
        do_read("post_rst", 32'h100, 32'hDEADBEAA, 1'b0);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sdram_cache_ctrl.md
Name: sdram_cache_ctrl

Overview:
- Direct-mapped, write-through, one-word-per-line cache between the AHB-lite SRAM wrapper's user interface (rd/wr/addr/data/mask/busy) and a simple word-wide SDRAM backend request/ack port.
- Invalidates all lines after reset, then serves read hits in one cycle.
- Read misses fill from the backend; every write is forwarded to the backend.

Parameters:
- ADDR_WIDTH, 32, byte-address width of i_addr and mem_addr.
- INDEX_BITS, 10, log2 of the number of lines (1024 lines × 32-bit data).

Ports:
- clk  in  1  single system clock, rising edge.
- rst_x  in  1  reset, asynchronous, active-high.
- w_init_done  out  1  high once the invalidation sweep is finished; stays high.
- i_rd_en  in  1  one-cycle read request; only issued while o_busy=0.
- i_wr_en  in  1  write request; held high until o_busy is seen high.
- i_addr  in  ADDR_WIDTH  byte address; bits [1:0] are ignored (word aligned).
- i_data  in  32  write data.
- i_mask  in  4  byte-enable mask for writes; bit n selects byte n. Ignored on reads.
- o_data  out  32  read data.
- o_busy  out  1  controller cannot accept a request; read data not yet valid.
- state  out  7  current FSM encoding, for debug.
- c_oe  out  1  one-cycle pulse when o_data carries new read data.
- mem_req  out  1  backend request; held until mem_ack.
- mem_we  out  1  1 = write, 0 = read. Stable while mem_req is high.
- mem_addr  out  ADDR_WIDTH  word-aligned backend address.
- mem_wdata  out  32  backend write data.
- mem_wmask  out  4  backend byte mask.
- mem_ack  in  1  one-cycle completion strobe from the backend.
- mem_rdata  in  32  backend read data; valid in the mem_ack cycle for reads.

Behaviour:
- Address split: index = i_addr[INDEX_BITS+1:2]; tag = i_addr[ADDR_WIDTH-1:INDEX_BITS+2].
- Each line holds a valid bit, the tag, and 32 data bits. Line RAM is synchronous-read.
- State encodings: INIT=0, IDLE=1, LOOKUP=2, RD_MISS=3, WR_MEM=4.
- Reset (asynchronous, rst_x=1):
  - state=INIT, index counter=0, w_init_done=0, o_busy=1.
  - o_data=0, c_oe=0, mem_req=0, mem_we=0.
  - All address/data/mask outputs are 0.
- INIT:
  - Clears the valid bit of one line per cycle, index 0 up to 2^INDEX_BITS-1.
  - After the last line: w_init_done=1, state goes to IDLE. o_busy stays 1 throughout INIT.
  - Requests arriving during INIT are ignored.
- IDLE, o_busy=0:
  - i_rd_en: latch the address, issue the line RAM read, go to LOOKUP.
  - Else i_wr_en: latch address, data and mask, go to WR_MEM.
  - If both are high, the read wins; the write is ignored and the wrapper keeps i_wr_en high.
- LOOKUP, the cycle after i_rd_en:
  - Hit = valid && tag match.
  - On a hit:
    - o_busy=0 combinationally in this cycle.
    - o_data = line data in this same cycle; the value is also registered so it holds until the next read completes.
    - c_oe=1 for this cycle.
    - Next state is LOOKUP if i_rd_en=1 (back-to-back reads supported), otherwise IDLE.
  - On a miss: o_busy=1 combinationally, go to RD_MISS.
- RD_MISS:
  - Drive mem_req=1, mem_we=0, mem_addr = latched address.
  - On mem_ack: write mem_rdata into the line (valid=1, new tag), register o_data=mem_rdata, pulse c_oe, go to IDLE.
- WR_MEM (write-through):
  - Drive mem_req=1, mem_we=1, with latched address, data and mask.
  - On entry, if the line hits, merge the masked bytes into the cached data. Misses do not allocate.
  - On mem_ack: go to IDLE. o_data is unchanged by writes.
- o_busy:
  - 1 in INIT, RD_MISS and WR_MEM.
  - In LOOKUP it equals !hit.
  - 0 in IDLE.
  - After the cycle in which i_wr_en is accepted, o_busy is 1 for at least one cycle, so the wrapper can drop i_wr_en.
- Requests are only sampled in IDLE, or in LOOKUP on a hit. They are ignored in all other states.
- Backend ack arriving while mem_req=0: ignored.
- Reset mid-transaction: drop mem_req at once, restart INIT, w_init_done=0.

Decomposition:
- Shared package holds:
  - the state encoding localparams;
  - MASK_W=4 and DATA_W=32;
  - the tag/index slicing helper functions.
- One sub-module, cache_line_ram: a synchronous dual-use RAM of {valid, tag, data}, with byte-write on the data field and a valid-clear port.

Test Plan:
- Init: release reset → w_init_done rises after exactly 1024 cycles; o_busy=1 until then, then 0.
- Cold read 0x0000_0100, backend returns 0xDEADBEEF after 5 cycles:
  - o_busy=1 from the cycle after i_rd_en until the ack;
  - then o_data=0xDEADBEEF and c_oe pulses once.
- Repeat read 0x100 → hit: o_busy stays 0, o_data=0xDEADBEEF the next cycle, mem_req never asserted.
- Write 0x100 with data 0x000000AA and mask 4'b0001:
  - mem_req/mem_we high with mask 0001 until ack;
  - a following read of 0x100 hits with 0xDEADBEAA.
- Aliased read 0x1100 (same index, new tag) → miss and refill; a subsequent read of 0x100 misses again.
- Back-to-back reads 0x100, 0x104 (both hit) on consecutive cycles → two consecutive c_oe pulses with the correct data; assert reset during an RD_MISS → mem_req drops at once and the INIT sweep restarts.
